// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned MASK_W   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } arb_state_e;

  typedef enum logic {
    OwnIfu,
    OwnLsu
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant picker: LSU has priority unless the IFU has been starved for STARVE_LIMIT grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                ifu_valid_i,
  input  logic                lsu_valid_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                ifu_gnt_o,
  output logic                lsu_gnt_o
);

  logic ifu_forced;

  assign ifu_forced = ifu_valid_i & (starve_cnt_i == STARVE_W'(STARVE_LIMIT));
  assign ifu_gnt_o  = ifu_forced | (ifu_valid_i & ~lsu_valid_i);
  assign lsu_gnt_o  = lsu_valid_i & ~ifu_forced;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU (read) and LSU (read/write).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_req_wen,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WaitLoad = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                ifu_gnt, lsu_gnt;
  logic                in_access, in_resp;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .starve_cnt_i(starve_q),
    .ifu_gnt_o   (ifu_gnt),
    .lsu_gnt_o   (lsu_gnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    resp_d   = resp_q;
    unique case (state_q)
      StIdle: begin
        if (ifu_gnt) begin
          owner_d  = OwnIfu;
          addr_d   = ifu_req_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          wait_d   = WaitLoad;
          starve_d = '0;
          state_d  = (LATENCY == 0) ? StAccess : StWait;
        end else if (lsu_gnt) begin
          owner_d = OwnLsu;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          wait_d  = WaitLoad;
          // Only grants that actually make the IFU wait count towards starvation.
          if (ifu_req_valid && (starve_q != StarveMax)) starve_d = starve_q + 1'b1;
          state_d = (LATENCY == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (wait_q == '0) state_d = StAccess;
        else              wait_d  = wait_q - 1'b1;
      end
      StAccess: begin
        resp_d  = wen_q ? '0 : mem_rdata;
        state_d = StResp;
      end
      StResp: begin
        if ((owner_q == OwnIfu) ? ifu_resp_ready : lsu_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnIfu;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wait_q   <= '0;
      starve_q <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      resp_q   <= resp_d;
    end
  end

  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  assign ifu_req_ready  = ~reset & (state_q == StIdle) & ifu_gnt;
  assign lsu_req_ready  = ~reset & (state_q == StIdle) & lsu_gnt;

  // Strobes are gated by reset so an interrupted access never reaches memory.
  assign mem_ren   = ~reset & in_access & ~wen_q;
  assign mem_wen   = ~reset & in_access & wen_q;
  assign mem_raddr = (in_access && !wen_q) ? addr_q : '0;
  assign mem_waddr = (in_access && wen_q) ? addr_q : '0;
  assign mem_wdata = (in_access && wen_q) ? wdata_q : '0;
  assign mem_wmask = (in_access && wen_q) ? wmask_q : '0;

  assign ifu_resp_valid = ~reset & in_resp & (owner_q == OwnIfu);
  assign lsu_resp_valid = ~reset & in_resp & (owner_q == OwnLsu);
  assign ifu_resp_data  = (in_resp && owner_q == OwnIfu) ? resp_q : '0;
  assign lsu_resp_data  = (in_resp && owner_q == OwnLsu) ? resp_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: three arbiters (LATENCY 0/1/3) on shared stimulus, each checked by a timestamp model.
module tb_mem_port_arbiter;

  localparam int unsigned SL = 4;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid, ifu_resp_ready;
  logic [63:0] ifu_req_addr;
  logic        lsu_req_valid, lsu_req_wen, lsu_resp_ready;
  logic [63:0] lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;

  logic [2:0]  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid, mem_ren, mem_wen;
  logic [63:0] ifu_resp_data [3];
  logic [63:0] lsu_resp_data [3];
  logic [63:0] mem_raddr [3];
  logic [63:0] mem_waddr [3];
  logic [63:0] mem_wdata [3];
  logic [7:0]  mem_wmask [3];
  logic [63:0] mem_rdata [3];

  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] memfn(input logic [63:0] a);
    if (a == 64'h8000_0010) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0] + a[63:32]};
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    mem_port_arbiter #(
      .LATENCY     (L),
      .STARVE_LIMIT(SL)
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready[g]),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid[g]),
      .ifu_resp_ready(ifu_resp_ready),
      .ifu_resp_data (ifu_resp_data[g]),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready[g]),
      .lsu_req_wen   (lsu_req_wen),
      .lsu_req_addr  (lsu_req_addr),
      .lsu_req_wdata (lsu_req_wdata),
      .lsu_req_wmask (lsu_req_wmask),
      .lsu_resp_valid(lsu_resp_valid[g]),
      .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_data (lsu_resp_data[g]),
      .mem_ren       (mem_ren[g]),
      .mem_raddr     (mem_raddr[g]),
      .mem_wen       (mem_wen[g]),
      .mem_waddr     (mem_waddr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_wmask     (mem_wmask[g]),
      .mem_rdata     (mem_rdata[g])
    );

    assign mem_rdata[g] = memfn(mem_raddr[g]);

    // Model: one outstanding request tracked by cycles since accept.
    bit          busy = 0;
    bit          own_lsu = 0;
    bit          m_wen = 0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_wmask = '0;
    int          age = 0;
    int          starve = 0;

    always @(negedge clock) begin : model
      bit          e_irdy, e_lrdy, e_ren, e_wen, e_iv, e_lv, ifu_win, lsu_win;
      logic [63:0] e_data;
      e_irdy = 0; e_lrdy = 0; e_ren = 0; e_wen = 0; e_iv = 0; e_lv = 0;
      e_data = '0;
      if (reset) begin
        busy   = 0;
        starve = 0;
      end else if (!busy) begin
        ifu_win = ifu_req_valid && (!lsu_req_valid || starve == SL);
        lsu_win = lsu_req_valid && !ifu_win;
        e_irdy  = ifu_win;
        e_lrdy  = lsu_win;
        if (ifu_win) begin
          busy = 1; own_lsu = 0; m_wen = 0; m_addr = ifu_req_addr; age = 0; starve = 0;
        end else if (lsu_win) begin
          busy = 1; own_lsu = 1; m_wen = lsu_req_wen; m_addr = lsu_req_addr;
          m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask; age = 0;
          if (ifu_req_valid && starve < SL) starve++;
        end
      end else begin
        age++;
        if (age == L + 1) begin
          e_ren = !m_wen;
          e_wen = m_wen;
        end
        if (age >= L + 2) begin
          e_data = m_wen ? 64'h0 : memfn(m_addr);
          e_iv   = !own_lsu;
          e_lv   = own_lsu;
          if (own_lsu ? lsu_resp_ready : ifu_resp_ready) busy = 0;
        end
      end
      check($sformatf("u%0d ifu_req_ready", g), ifu_req_ready[g], e_irdy);
      check($sformatf("u%0d lsu_req_ready", g), lsu_req_ready[g], e_lrdy);
      check($sformatf("u%0d mem_ren", g), mem_ren[g], e_ren);
      check($sformatf("u%0d mem_wen", g), mem_wen[g], e_wen);
      check($sformatf("u%0d ifu_resp_valid", g), ifu_resp_valid[g], e_iv);
      check($sformatf("u%0d lsu_resp_valid", g), lsu_resp_valid[g], e_lv);
      if (e_ren) check($sformatf("u%0d mem_raddr", g), mem_raddr[g], m_addr);
      if (e_wen) begin
        check($sformatf("u%0d mem_waddr", g), mem_waddr[g], m_addr);
        check($sformatf("u%0d mem_wdata", g), mem_wdata[g], m_wdata);
        check($sformatf("u%0d mem_wmask", g), mem_wmask[g], m_wmask);
      end
      if (e_iv) check($sformatf("u%0d ifu_resp_data", g), ifu_resp_data[g], e_data);
      if (e_lv) check($sformatf("u%0d lsu_resp_data", g), lsu_resp_data[g], e_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    lsu_req_wen   = 0;
  endtask

  task automatic do_reset();
    step();
    reset = 1;
    clear_reqs();
    lsu_req_valid = 1;
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      check("reset lsu_req_ready", lsu_req_ready[g], 0);
      check("reset lsu_resp_valid", lsu_resp_valid[g], 0);
    end
    lsu_req_valid = 0;
  endtask

  initial begin
    int   n;
    bit   found;
    logic gnt [10];
    reset = 1;
    clear_reqs();
    ifu_req_addr = '0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    do_reset();

    // Single load: grant at 0, strobe at L+1, response at L+2.
    step(); reset = 0;
    lsu_req_valid = 1; lsu_req_addr = 64'h8000_0010;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin step(); lsu_req_valid = 0; end
      @(negedge clock);
      if (c == 0) check("load accept", lsu_req_ready[1], 1);
      check("load mem_ren", mem_ren[1], (c == 2));
      for (int g = 0; g < 3; g++) check("latency resp_valid", lsu_resp_valid[g], (c == lat(g) + 2));
      if (c == 3) check("load data", lsu_resp_data[1], 64'h1122_3344_5566_7788);
    end

    // Single store.
    step();
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 64'h8000_0020;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin step(); lsu_req_valid = 0; end
      @(negedge clock);
      check("store mem_wen", mem_wen[1], (c == 2));
      check("store mem_ren", mem_ren[1], 0);
      if (c == 2) begin
        check("store waddr", mem_waddr[1], 64'h8000_0020);
        check("store wdata", mem_wdata[1], 64'h0000_0000_DEAD_BEEF);
        check("store wmask", mem_wmask[1], 8'h0F);
      end
      if (c == 3) begin
        check("store ack valid", lsu_resp_valid[1], 1);
        check("store ack data", lsu_resp_data[1], 0);
      end
    end

    // Starvation: both valid continuously.
    do_reset();
    step(); reset = 0;
    ifu_req_valid = 1; ifu_req_addr = 64'h1000;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 64'h2000;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      if (c > 0) step();
      @(negedge clock);
      if (lsu_req_ready[1]) begin gnt[n] = 0; n++; end
      else if (ifu_req_ready[1]) begin gnt[n] = 1; n++; end
    end
    check("starve grant count", 64'(n), 10);
    for (int i = 0; i < n; i++) check($sformatf("grant %0d is ifu", i), gnt[i], (i % 5 == 4));

    // Held response.
    do_reset();
    step(); reset = 0;
    lsu_req_valid = 1; lsu_req_addr = 64'h8000_0040; lsu_resp_ready = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c > 0) begin step(); lsu_req_valid = 0; end
      @(negedge clock);
      found = lsu_resp_valid[1];
    end
    if (!found) check("hold wait for resp", 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(); ifu_req_valid = 1; lsu_req_valid = 1;
      @(negedge clock);
      check("hold valid", lsu_resp_valid[1], 1);
      check("hold data", lsu_resp_data[1], memfn(64'h8000_0040));
      check("hold no grant", {ifu_req_ready[1], lsu_req_ready[1]}, 0);
      check("hold no strobe", {mem_ren[1], mem_wen[1]}, 0);
    end
    step(); clear_reqs(); lsu_resp_ready = 1;
    @(negedge clock);
    check("hold release valid", lsu_resp_valid[1], 1);
    step();
    @(negedge clock);
    check("hold after release", lsu_resp_valid[1], 0);

    // Reset during store access.
    do_reset();
    step(); reset = 0;
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 64'h8000_0020;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    @(negedge clock);
    step(); clear_reqs();
    @(negedge clock);
    step(); reset = 1;
    @(negedge clock);
    check("reset in access mem_wen", mem_wen[1], 0);
    for (int c = 3; c < 7; c++) begin
      step(); reset = 0;
      @(negedge clock);
      check("post reset resp_valid", lsu_resp_valid[1], 0);
      check("post reset strobes", {mem_ren[1], mem_wen[1]}, 0);
    end
    step(); lsu_req_valid = 1; lsu_req_addr = 64'h3000;
    @(negedge clock);
    check("post reset idle accept", lsu_req_ready[1], 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset          = ($urandom_range(0, 249) == 0);
      ifu_req_valid  = ($urandom_range(0, 2) != 0);
      lsu_req_valid  = ($urandom_range(0, 2) != 0);
      lsu_req_wen    = $urandom_range(0, 1) == 1;
      ifu_req_addr   = {$urandom, $urandom};
      lsu_req_addr   = {$urandom, $urandom};
      lsu_req_wdata  = {$urandom, $urandom};
      lsu_req_wmask  = 8'($urandom_range(0, 255));
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
